// File: rtl/display_arbiter_pkg.sv
// Shared types, constants and helpers for the display arbiter.
package display_arbiter_pkg;

    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned VAL_W      = 16;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIG_W      = 2;

    localparam int unsigned REQ_MAQ1 = 0;
    localparam int unsigned REQ_MAQ2 = 1;
    localparam int unsigned REQ_MAQ3 = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHARE = 2'd2
    } arb_state_e;

    // Hex digit to active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // One-hot of the lowest set bit (highest priority requester)
    function automatic logic [NUM_REQ-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        return v & (~v + NUM_REQ'(1));
    endfunction

    function automatic logic [VAL_W-1:0] sel_val(
        input logic [NUM_REQ-1:0] oh,
        input logic [VAL_W-1:0]   v0,
        input logic [VAL_W-1:0]   v1,
        input logic [VAL_W-1:0]   v2
    );
        logic [VAL_W-1:0] r;
        r = '0;
        if (oh[REQ_MAQ1])      r = v0;
        else if (oh[REQ_MAQ2]) r = v1;
        else if (oh[REQ_MAQ3]) r = v2;
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decoder
    import display_arbiter_pkg::*;
(
    input  logic [NIB_W-1:0] i_nibble,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority, minimum-dwell arbiter for a shared 4-digit multiplexed
// 7-segment display, with a frame-coherent shadow of the owner's value.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 4,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [VAL_W-1:0]  val0,
    input  logic [VAL_W-1:0]  val1,
    input  logic [VAL_W-1:0]  val2,
    output logic [NUM_REQ-1:0] grant,
    output logic              d1,
    output logic              d2,
    output logic              d3,
    output logic              d4,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic              ponto
);

    localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant_nxt;
    logic                w_load;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [PRE_W-1:0]    r_presc;
    logic [DIG_W-1:0]    r_digit;
    logic [VAL_W-1:0]    r_shadow;

    logic                w_scan_tick;
    logic                w_scan_wrap;
    logic [NUM_REQ-1:0]  w_others;
    logic [NUM_REQ-1:0]  w_higher;
    logic [NIB_W-1:0]    w_nibble;
    logic [SEG_W-1:0]    w_seg_dec;
    logic [NUM_DIGITS-1:0] w_digit_en;
    logic [SEG_W-1:0]    w_seg;
    logic                w_dp;

    assign w_scan_tick = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_scan_wrap = w_scan_tick && (r_digit == DIG_W'(NUM_DIGITS - 1));
    assign w_others    = req & ~r_grant;
    // Owner is one-hot, so owner-1 masks exactly the higher-priority bits
    assign w_higher    = req & NUM_REQ'(r_grant - NUM_REQ'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_load      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant_nxt = lowest_set(req);
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_hold_cnt == '0) w_state_nxt = SHARE;
            end
            SHARE: begin
                if (!(|(req & r_grant))) begin
                    if (|w_others) begin
                        w_grant_nxt = lowest_set(w_others);
                        w_load      = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_grant_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end else if (|w_higher) begin
                    w_grant_nxt = lowest_set(w_higher);
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Grant, dwell counter, shadow and free-running scan
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= '0;
            r_hold_cnt <= '0;
            r_presc    <= '0;
            r_digit    <= '0;
            r_shadow   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            if (w_load)
                r_hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
            else if (r_state == HOLD && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
            if (w_load)
                r_shadow <= sel_val(w_grant_nxt, val0, val1, val2);
            else if (w_scan_wrap && |r_grant)
                r_shadow <= sel_val(r_grant, val0, val1, val2);
            if (w_scan_tick) begin
                r_presc <= '0;
                r_digit <= r_digit + DIG_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    always_comb begin
        w_nibble = '0;
        unique case (r_digit)
            2'd0:    w_nibble = r_shadow[15:12];
            2'd1:    w_nibble = r_shadow[11:8];
            2'd2:    w_nibble = r_shadow[7:4];
            default: w_nibble = r_shadow[3:0];
        endcase
    end

    seg7_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_digit_en = '1;
        w_seg      = '1;
        w_dp       = 1'b1;
        if (r_state != IDLE) begin
            w_digit_en = ~(NUM_DIGITS'(4'b1000) >> r_digit);
            w_seg      = w_seg_dec;
            w_dp       = ~((r_digit == DIG_W'(NUM_DIGITS - 1)) && (|w_others));
        end
    end

    assign grant                 = r_grant;
    assign {d1, d2, d3, d4}      = w_digit_en;
    assign {g, f, e, d, c, b, a} = w_seg;
    assign ponto                 = w_dp;

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Arbitrates the shared 4-digit multiplexed 7-segment display between the three process machines (requester 0 = maq1 alarm/sensor status, 1 = maq2 fill/valve status, 2 = maq3 output count). It sits between the machines and the display pins.
- It grants the display to one requester at a time by fixed priority, with a guaranteed minimum dwell.
- It latches the granted 16-bit value and scans it across d1..d4.

## Interface
Parameters:
- SCAN_DIV, default 4: clk cycles each digit stays enabled; must be ≥1.
- HOLD_CYCLES, default 16: minimum cycles a new grant is held before preemption or release; must be ≥1.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 3: request per requester; bit 0 is highest priority.
- val0, input, 16: hex value for requester 0; nibble [15:12] → d1.
- val1, input, 16: hex value for requester 1.
- val2, input, 16: hex value for requester 2.
- grant, output, 3: one-hot current owner; 000 when idle.
- d1, d2, d3, d4, output, 1 each: digit enables, active-low.
- a, b, c, d, e, f, g, output, 1 each: segments, active-low.
- ponto, output, 1: decimal point, active-low.

## Operation
- States: IDLE, HOLD, SHARE.
- IDLE: grant=000; d1..d4=1; segments=1; ponto=1.
  - If req≠0, grant the highest-priority set bit, load shadow with that requester's val, load hold_cnt=HOLD_CYCLES-1, go to HOLD.
- HOLD: grant is frozen regardless of req, including the owner dropping its request.
  - hold_cnt decrements each cycle; at hold_cnt==0, go to SHARE.
- SHARE, evaluated in order:
  - Owner req low and other req pending: regrant the highest pending, reload shadow and hold_cnt, go to HOLD.
  - Owner req low and none pending: go to IDLE, clear grant.
  - Higher-priority req pending: preempt to it, reload shadow and hold_cnt, go to HOLD.
  - Otherwise stay in SHARE.
- Shadow refresh while owned:
  - Shadow is reloaded from the owner's val only at scan wrap, i.e. the prescaler terminal cycle with digit index 3→0.
  - No tearing within a scan frame.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1, wrapping.
  - At terminal count, digit index 0..3 increments and wraps.
  - Scan runs in every state; only output enables are blanked in IDLE.
- Outputs, outside IDLE:
  - Digit index i drives the active-low one-hot enable d(i+1).
  - Segments show the hex decode (0–F) of shadow nibble [15-4i:12-4i].
- ponto is low only while digit index = 3, state≠IDLE, and any non-owner req is high ("others waiting").

## Timing
- Reset values:
  - State IDLE, grant=000, hold_cnt=0, prescaler=0, digit index=0, shadow=0.
  - d1..d4=1, a..g=1, ponto=1.
- rst asserted mid-operation returns to these values on the next edge, regardless of state or req.
- Grant latency: req rising at edge n (IDLE) → grant and shadow valid after edge n, i.e. 1 cycle.
- Minimum dwell: a grant issued at edge n cannot change before edge n+HOLD_CYCLES+1. HOLD lasts HOLD_CYCLES cycles; the SHARE decision is evaluated on the following edge.
- Outputs a..g, d1..d4, ponto are combinational decodes of registered state, prescaler, digit index and shadow. There is no additional latency.
- Simultaneous requests: the lowest index wins; ties never split.
- Owner drop plus a new request on the same edge in SHARE resolves as a regrant to the highest pending request, never through IDLE.
- A preemption or regrant reloads the shadow immediately, not at scan wrap.
- The prescaler and digit index are not reset by grant changes.

## Structure
- Package display_arbiter_pkg holds:
  - The state enum (IDLE, HOLD, SHARE).
  - The 16-entry hex→active-low 7-bit segment constant table, ordered {g,f,e,d,c,b,a}.
  - Requester index constants (REQ_MAQ1=0, REQ_MAQ2=1, REQ_MAQ3=2).
- One sub-module, seg7_hex_decoder: 4-bit nibble in, 7 active-low segments out, using the package table.
- Arbiter FSM, hold counter, scan prescaler and shadow register live in display_arbiter.

## Test plan
- Reset/idle: rst high 2 cycles, req=000 → grant=000, d1..d4=1111, a..g all 1, ponto=1 throughout.
- Single grant and scan: SCAN_DIV=4, req=100, val2=16'h1234 → grant=100 after 1 cycle.
  - d1 low showing "1" for 4 cycles, then d2 "2", d3 "3", d4 "4", then wrap to d1.
- Hold then preempt: HOLD_CYCLES=16, req=010 granted, req[0] raised 3 cycles later with val0=16'hE001.
  - grant stays 010 until 17 cycles after the original grant, then 001; shadow=E001 the same edge.
- Priority tie: req=111 from IDLE → grant=001.
  - ponto low whenever d4 is active.
- Owner drop during HOLD: req falls 2 cycles after grant → grant held full HOLD_CYCLES, then IDLE (or regrant if others pending).
- Reset mid-SHARE with req=011 → next edge all outputs at reset values; grant=001 one cycle after rst deasserts.
